col2img_pack: RTL and testbench

- Output-side counterpart of the img2col mapper, on the return path from the PU array to AXI.
- Accepts convolution results in raster order, one word per accepted transfer, and assembles them into output-feature-map rows.
- Ping-pong row buffers decouple input from output.
- Streams each completed row toward AXI as word pairs (out1/out2), mirroring the new1/new2 pair format used on the input side.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/col2img_pack_row_buf.sv | 27 ++
 rtl/col2img_pack.sv | 143 ++++++++++++++
 tb/tb_col2img_pack.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions used by the img2col mapper and col2img packer.
package cnn_pkg;

  localparam int ROW_DIM = 28;
  localparam int KER_DIM = 5;
  localparam int OUT_DIM = ROW_DIM - KER_DIM + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } c2i_state_e;

endpackage

// File: rtl/col2img_pack_row_buf.sv
// One output-feature-map row of storage: single write port, even/odd pair read.
module row_buf
  import cnn_pkg::*;
#(
  parameter int data_width = 16,
  parameter int out_dim    = OUT_DIM
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [$clog2(out_dim)-1:0]       waddr,
  input  logic [data_width-1:0]            wdata,
  input  logic [$clog2(out_dim/2)-1:0]     pair,
  output logic [data_width-1:0]            rd_even,
  output logic [data_width-1:0]            rd_odd
);

  logic [data_width-1:0] mem_q [out_dim];

  // Row storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rd_even = mem_q[{pair, 1'b0}];
  assign rd_odd  = mem_q[{pair, 1'b1}];

endmodule

// File: rtl/col2img_pack.sv
// Collects raster-order results into ping-pong rows and streams each row as word pairs.
module col2img_pack
  import cnn_pkg::*;
#(
  parameter int data_width = 16,
  parameter int out_dim    = OUT_DIM,
  parameter int idx_width  = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [data_width-1:0] res_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out1,
  output logic [data_width-1:0] out2,
  output logic                  out_last,
  output logic [idx_width-1:0]  row_idx,
  output logic                  frame_done
);

  localparam int AW = $clog2(out_dim);
  localparam int BW = $clog2(out_dim/2);
  localparam logic [AW-1:0]        PTR_LAST  = AW'(out_dim - 1);
  localparam logic [BW-1:0]        BEAT_LAST = BW'(out_dim/2 - 1);
  localparam logic [idx_width-1:0] ROW_LAST  = idx_width'(out_dim - 1);
  localparam logic [idx_width-1:0] ROW_N     = idx_width'(out_dim);

  c2i_state_e           state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [idx_width-1:0] rows_in_q, rows_in_d;
  logic [idx_width-1:0] rows_out_q, rows_out_d;

  logic                 wr_acc, rd_acc, row_in_done, row_out_done;
  logic [1:0][data_width-1:0] rd_even, rd_odd;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      row_buf #(.data_width(data_width), .out_dim(out_dim)) u_row_buf (
        .clk    (clk),
        .we     (wr_acc && (wr_sel_q == 1'(gi))),
        .waddr  (wr_ptr_q),
        .wdata  (res_data),
        .pair   (beat_q),
        .rd_even(rd_even[gi]),
        .rd_odd (rd_odd[gi])
      );
    end
  endgenerate

  // Handshakes, FSM next state and buffer bookkeeping.
  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    wr_ptr_d   = wr_ptr_q;
    beat_d     = beat_q;
    rows_in_d  = rows_in_q;
    rows_out_d = rows_out_q;

    res_ready    = (state_q == RUN) && !full_q[wr_sel_q] && (rows_in_q != ROW_N);
    out_valid    = full_q[rd_sel_q];
    wr_acc       = res_valid && res_ready;
    rd_acc       = out_valid && out_ready;
    row_in_done  = wr_acc && (wr_ptr_q == PTR_LAST);
    row_out_done = rd_acc && (beat_q == BEAT_LAST);

    out1       = out_valid ? rd_even[rd_sel_q] : '0;
    out2       = out_valid ? rd_odd[rd_sel_q]  : '0;
    out_last   = out_valid && (beat_q == BEAT_LAST);
    row_idx    = rows_out_q;
    frame_done = (state_q == DONE);

    // Write and read sides touch different buffers, so both may update together.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (row_in_done) begin
        wr_ptr_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        rows_in_d        = rows_in_q + 1'b1;
      end
    end
    if (rd_acc) begin
      beat_d = beat_q + 1'b1;
      if (row_out_done) begin
        beat_d           = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        rows_out_d       = rows_out_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (row_out_done && (rows_out_q == ROW_LAST)) state_d = DONE;
      DONE: begin
        // Frame fully drained: rewind everything for the next start.
        state_d    = IDLE;
        full_d     = '0;
        wr_sel_d   = 1'b0;
        rd_sel_d   = 1'b0;
        wr_ptr_d   = '0;
        beat_d     = '0;
        rows_in_d  = '0;
        rows_out_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_ptr_q   <= '0;
      beat_q     <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      beat_q     <= beat_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
    end
  end

endmodule

// File: tb/tb_col2img_pack.sv
// Scoreboard bench for col2img_pack: driver pushes expected pairs, monitor pops on handshake.
module tb_col2img_pack;

  localparam int DW = 16;
  localparam int OD = 24;
  localparam int IW = 5;
  localparam int NW = OD*OD;

  logic          clk = 0, nrst = 0, start = 0, res_valid = 0, out_ready = 0;
  logic [DW-1:0] res_data = '0;
  logic          res_ready, out_valid, out_last, frame_done;
  logic [DW-1:0] out1, out2;
  logic [IW-1:0] row_idx;

  typedef struct {
    int e1; int e2; int last; int row;
  } exp_t;
  exp_t exp_q[$];

  int chk = 0, err = 0;
  int cyc = 0;
  int pair_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int last_pair_cyc = -10, pair23_cyc = -10;
  bit abort = 0, rnd_ready = 0, rnd_gap = 0;

  col2img_pack #(.data_width(DW), .out_dim(OD), .idx_width(IW)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .out_last(out_last),
    .row_idx(row_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    chk++;
    if (act != req) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Randomised downstream ready when enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom % 2) == 1;
  end

  // Monitor: compare every handshaked pair against the scoreboard head.
  logic          held = 0;
  logic [DW-1:0] h1, h2;
  logic          hl;
  always @(negedge clk) begin
    if (held && out_valid) begin
      check("hold_out1", out1, h1);
      check("hold_out2", out2, h2);
      check("hold_last", out_last, hl);
    end
    held = out_valid && !out_ready;
    h1 = out1; h2 = out2; hl = out_last;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out1", out1, e.e1);
        check("out2", out2, e.e2);
        check("out_last", out_last, e.last);
        check("row_idx", row_idx, e.row);
      end
      pair_cnt++;
      if (out2 == DW'(NW-1)) last_pair_cyc = cyc;
      if (out2 == 16'd23) pair23_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      check("done_timing", cyc, last_pair_cyc + 1);
    end
  end

  task automatic send_word(input int v);
    int n = 0;
    res_valid = 1; res_data = DW'(v);
    forever begin
      @(negedge clk);
      if (abort) break;
      if (res_ready) begin
        acc_cnt++;
        if (v % 2 == 1) begin
          exp_t e;
          e.e1 = v - 1; e.e2 = v; e.last = ((v % OD) == OD-1); e.row = v / OD;
          exp_q.push_back(e);
        end
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 3000) begin check("send_timeout", n, 0); break; end
    end
    res_valid = 0;
  endtask

  task automatic send_frame();
    for (int v = 0; v < NW; v++) begin
      if (abort) break;
      send_word(v);
      if (rnd_gap && ($urandom % 3 == 0)) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin @(negedge clk); n++; end
    check("frame_done_seen", done_cnt > 0, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic new_frame();
    pair_cnt = 0; done_cnt = 0; acc_cnt = 0;
    last_pair_cyc = -10; pair23_cyc = -10;
  endtask

  task automatic end_frame(input string tag);
    check({tag, "_pairs"}, pair_cnt, NW/2);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset values.
    check("rst_res_ready", res_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out1", out1, 0);
    check("rst_out2", out2, 0);
    check("rst_row_idx", row_idx, 0);
    nrst = 1;

    // Stray res_valid while IDLE.
    res_valid = 1; res_data = 16'hBEEF;
    repeat (5) begin
      @(negedge clk);
      check("idle_res_ready", res_ready, 0);
      check("idle_out_valid", out_valid, 0);
    end
    @(posedge clk); #1 res_valid = 0;

    // Basic frame, always ready, back-to-back.
    new_frame();
    out_ready = 1;
    pulse_start();
    send_frame();
    wait_done();
    end_frame("basic");

    // Backpressure: downstream stalled during input.
    new_frame();
    out_ready = 0;
    pulse_start();
    fork send_frame(); join_none
    begin
      int n = 0;
      while (acc_cnt < 48 && n < 500) begin @(negedge clk); n++; end
    end
    repeat (10) begin
      @(negedge clk);
      check("bp_res_ready_low", res_ready, 0);
    end
    check("bp_accepted", acc_cnt, 48);
    check("bp_out_valid", out_valid, 1);
    check("bp_out1", out1, 0);
    check("bp_out2", out2, 1);
    @(posedge clk); #1 out_ready = 1;
    begin
      int n = 0;
      @(negedge clk);
      while (!res_ready && n < 100) begin @(negedge clk); n++; end
      check("bp_ready_return", cyc, pair23_cyc + 1);
    end
    wait_done();
    end_frame("bp");

    // Random ready and input gaps, with a stray start mid-frame.
    new_frame();
    rnd_ready = 1; rnd_gap = 1;
    pulse_start();
    fork send_frame(); join_none
    repeat (200) @(posedge clk);
    pulse_start();
    wait_done();
    end_frame("rnd");
    rnd_ready = 0; rnd_gap = 0;

    // Reset while row 5 streams.
    new_frame();
    @(posedge clk); #1 out_ready = 1;
    pulse_start();
    fork send_frame(); join_none
    begin
      int n = 0;
      @(negedge clk);
      while (!(out_valid && row_idx == 5) && n < 2000) begin @(negedge clk); n++; end
      check("reached_row5", row_idx, 5);
    end
    #2;
    abort = 1; nrst = 0;
    #1;
    check("mid_rst_res_ready", res_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out1", out1, 0);
    check("mid_rst_out2", out2, 0);
    check("mid_rst_row_idx", row_idx, 0);
    check("mid_rst_frame_done", frame_done, 0);
    repeat (6) @(posedge clk);
    exp_q.delete();
    #1 nrst = 1; abort = 0;
    new_frame();
    pulse_start();
    send_frame();
    wait_done();
    end_frame("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
